// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises uart_rxd, samples mid-bit and presents each good
// byte with a one-cycle done strobe; a bad stop bit raises a one-cycle frame_err.
module uart_recv #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BPS_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rxd_d0_q, rxd_d1_q, rxd_d2_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic             start_edge;

  assign start_edge = rxd_d2_q & ~rxd_d1_q;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_d0_q <= 1'b1;
      rxd_d1_q <= 1'b1;
      rxd_d2_q <= 1'b1;
    end else begin
      rxd_d0_q <= uart_rxd;
      rxd_d1_q <= rxd_d0_q;
      rxd_d2_q <= rxd_d1_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      // Half-bit check rejects glitches and aligns later samples to mid-bit.
      START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxd_d1_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_d1_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      // Leave mid-stop-bit so a back-to-back start edge is not missed.
      STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rxd_d1_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign uart_data = data_q;
  assign uart_done = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: directed and random 8N1 frames scored against an expected-event
// queue (kind, byte, pin start cycle) built from the frame description.
module tb_uart_recv;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned UART_BPS = 100_000;
  localparam int          BPS      = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .uart_data(uart_data),
    .uart_done(uart_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;
  bit         prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the oldest expected frame event.
  always @(negedge sys_clk) begin
    exp_t e;
    int   lat;
    if (!sys_rst) begin
      if (uart_done || frame_err) begin
        check("exclusive", 32'(uart_done & frame_err), 32'd0);
        check("back_to_back", 32'(prev_pulse), 32'd0);
        check("pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          lat = cyc - e.t0;
          check("kind_err", 32'(frame_err), 32'(e.err));
          check("latency", 32'(lat), 32'(lat < 95 ? 95 : (lat > 99 ? 99 : lat)));
          if (uart_done && !e.err) model_data = e.data;
        end
      end
      check("uart_data", 32'(uart_data), 32'(model_data));
      prev_pulse = uart_done | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int gap);
    exp_t e;
    e.err  = !stop;
    e.data = b;
    e.t0   = cyc;
    exp_q.push_back(e);
    drive(1'b0, BPS);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], BPS);
      if (i == 1) check("busy_in_frame", 32'(rx_busy), 32'd1);
    end
    drive(stop, BPS);
    if (gap > 0) drive(1'b1, gap);
  endtask

  task automatic glitch(input int len);
    int busy_cnt;
    busy_cnt = 0;
    drive(1'b1, 12);
    for (int i = 0; i < len + 25; i++) begin
      drive((i < len) ? 1'b0 : 1'b1, 1);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy", 32'(busy_cnt), 32'(busy_cnt < 1 ? 1 : (busy_cnt > 7 ? 7 : busy_cnt)));
  endtask

  initial begin
    exp_t       e;
    logic [7:0] abort_b;
    logic [7:0] rb;
    logic       rstop;
    int         w;

    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    check("rst_data", 32'(uart_data), 32'h00);
    check("rst_done", 32'(uart_done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    sys_rst = 1'b0;
    drive(1'b1, 20);

    send(8'h55, 1'b1, 20);
    send(8'hA3, 1'b1, 0);
    send(8'h0F, 1'b1, 20);
    check("after_b2b", 32'(uart_data), 32'h0F);
    send(8'hC4, 1'b0, 20);
    check("after_ferr", 32'(uart_data), 32'h0F);
    glitch(3);

    // Sender and receiver both abandon 0x81 when reset hits mid data bit 4.
    abort_b = 8'h81;
    drive(1'b0, BPS);
    for (int i = 0; i < 4; i++) drive(abort_b[i], BPS);
    drive(abort_b[4], 5);
    sys_rst    = 1'b1;
    uart_rxd   = 1'b1;
    model_data = 8'h00;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("abort_data", 32'(uart_data), 32'h00);
    check("abort_busy", 32'(rx_busy), 32'd0);
    drive(1'b1, 30);
    send(8'h3C, 1'b1, 20);
    check("after_abort", 32'(uart_data), 32'h3C);

    // Break: exactly one frame_err for the whole low period.
    e.err  = 1'b1;
    e.data = 8'h00;
    e.t0   = cyc;
    exp_q.push_back(e);
    drive(1'b0, 300);
    drive(1'b1, 30);
    send(8'h7E, 1'b1, 20);
    check("after_break", 32'(uart_data), 32'h7E);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch(int'($urandom_range(1, 3)));
      end else begin
        rb    = 8'($urandom);
        rstop = ($urandom_range(0, 7) != 0);
        send(rb, rstop, rstop ? int'($urandom_range(0, 15)) : int'($urandom_range(3, 15)));
      end
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge sys_clk);
      #1;
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    drive(1'b1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
